// File: rtl/reg_ctl_pkg.sv
// Shared types and defaults for the register write controller.
// Holds the FSM state encoding and the index-width helper.
package reg_ctl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CLR  = 2'd2
  } state_e;

  localparam int N_REQ_DEF = 4;
  localparam int W_DEF     = 4;
  localparam int CNT_W_DEF = 8;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Requester-side bundle of the register write controller.
// Master drives requests, slave returns the acknowledges.
interface reg_write_arbiter_if
  import reg_ctl_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int W     = W_DEF
) ();

  logic [N_REQ-1:0]   req;
  logic [N_REQ*W-1:0] wdata;
  logic               clr_req;
  logic [N_REQ-1:0]   gnt;
  logic               clr_ack;

  modport master (
    output req,
    output wdata,
    output clr_req,
    input  gnt,
    input  clr_ack
  );

  modport slave (
    input  req,
    input  wdata,
    input  clr_req,
    output gnt,
    output clr_ack
  );

endinterface

// File: rtl/reg_write_arbiter_rr_pick.sv
// Combinational round-robin selector.
// Searches from last+1 upward, wrapping modulo N.
module rr_pick
  import reg_ctl_pkg::*;
#(
  parameter  int N  = N_REQ_DEF,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          valid,
  output logic [IW-1:0] idx
);

  int            k;
  logic [IW-1:0] k_idx;

  // Walk farthest-first so the nearest hit is the final assignment.
  always_comb begin
    valid = |req;
    idx   = '0;
    k     = 0;
    k_idx = '0;
    for (int i = N; i >= 1; i--) begin
      k     = (int'(last) + i) % N;
      k_idx = IW'(k);
      if (req[k_idx]) idx = k_idx;
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin write controller in front of a load/clear register.
// Clear requests beat writes; every transaction is one cycle.
module reg_write_arbiter
  import reg_ctl_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int W     = W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                clear,
  reg_write_arbiter_if.slave  bus,
  output logic                reg_load,
  output logic                reg_clr,
  output logic [W-1:0]        reg_i,
  output logic                busy,
  output logic [CNT_W-1:0]    wr_cnt
);

  localparam int IW = idx_w(N_REQ);

  state_e             state_q;
  logic [IW-1:0]      last_q;
  logic [N_REQ-1:0]   gnt_q;
  logic               clr_ack_q;
  logic               load_q;
  logic               clr_q;
  logic [W-1:0]       data_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               pick_v;
  logic [IW-1:0]      pick_idx;
  logic [W-1:0]       wdata_d;
  logic [N_REQ-1:0]   gnt_d;
  logic [W-1:0]       words [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_words
    assign words[g] = bus.wdata[g*W +: W];
  end

  rr_pick #(
    .N (N_REQ)
  ) u_pick (
    .req   (bus.req),
    .last  (last_q),
    .valid (pick_v),
    .idx   (pick_idx)
  );

  assign wdata_d = words[pick_idx];
  assign gnt_d   = N_REQ'(1) << pick_idx;

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q   <= IDLE;
      last_q    <= IW'(N_REQ - 1);
      gnt_q     <= '0;
      clr_ack_q <= 1'b0;
      load_q    <= 1'b0;
      clr_q     <= 1'b0;
      data_q    <= '0;
      cnt_q     <= '0;
    end else begin
      gnt_q     <= '0;
      clr_ack_q <= 1'b0;
      load_q    <= 1'b0;
      clr_q     <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // Pending writes simply wait out the clear.
          if (bus.clr_req) begin
            state_q   <= CLR;
            clr_ack_q <= 1'b1;
            clr_q     <= 1'b1;
          end else if (pick_v) begin
            state_q <= LOAD;
            gnt_q   <= gnt_d;
            load_q  <= 1'b1;
            data_q  <= wdata_d;
            last_q  <= pick_idx;
          end
        end
        LOAD: begin
          cnt_q   <= cnt_q + CNT_W'(1);
          state_q <= IDLE;
        end
        CLR: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.clr_ack = clr_ack_q;
  assign reg_load    = load_q;
  assign reg_clr     = clr_q;
  assign reg_i       = data_q;
  assign busy        = (state_q != IDLE);
  assign wr_cnt      = cnt_q;

endmodule
